cnn_zero_padding_multi_channel: RTL
===================================

Name: cnn_zero_padding_multi_channel

Overview:
- Upstream feeder for the 3x3 dilated multi-channel convolution stage.
- Takes an unpadded channel-major pixel stream (C channels of H rows by W pixels) over a valid/ready handshake.
- Emits each channel framed by PAD zero pixels on every side, as a valid-only stream that the convolution consumes directly.
- Removes the need to pre-pad feature maps in memory (e.g. 304x304 -> 306x306 for PAD=RATE=1).

Parameters:
- DATA_WIDTH, 32: pixel word width (raw bits, IEEE-754 single in practice; zero pad = all-zero word).
- IMAGE_WIDTH, 304: unpadded input width W.
- IMAGE_HEIGHT, 304: unpadded input height H.
- CHANNEL_NUM, 64: channels per frame C.
- PAD, 1: pad pixels per side; set equal to conv RATE. 0 = pass-through.
- Derived localparams: OUT_WIDTH = W+2*PAD; OUT_HEIGHT = H+2*PAD.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state).
- valid_in  in  1  input pixel valid; source holds pxl_in until accepted.
- pxl_in  in  DATA_WIDTH  input pixel.
- ready_out  out  1  combinational; high only in RUN when current position is interior. Transfer = valid_in & ready_out.
- valid_out  out  1  registered output valid.
- pxl_out  out  DATA_WIDTH  registered output pixel.
- frame_done  out  1  registered one-cycle pulse, coincident with the last valid_out of the frame.

Behaviour:
- Reset values: valid_out=0, pxl_out=0, frame_done=0, state=IDLE, col=row=ch=0. Asynchronous reset mid-frame aborts the frame; no partial-frame completion and no frame_done.
- Position counters: col 0..OUT_WIDTH-1, row 0..OUT_HEIGHT-1, ch 0..CHANNEL_NUM-1.
- Interior = PAD <= col < PAD+W and PAD <= row < PAD+H. Every other position is pad.
- States: IDLE, RUN.
- IDLE:
  - ready_out=0, valid_out<=0.
  - valid_in=1 -> RUN next cycle, counters at (0,0,0). The pixel is not consumed in IDLE.
- RUN, pad position:
  - valid_out<=1, pxl_out<=0, advance.
  - Independent of valid_in; never waits on the source.
- RUN, interior position:
  - If valid_in: pxl_out<=pxl_in, valid_out<=1, advance.
  - Else: valid_out<=0, counters hold (bubble propagates to output).
- Advance:
  - col++; at OUT_WIDTH-1 -> col=0, row++.
  - At last row -> row=0, ch++.
  - At last channel's final position -> counters to 0, state IDLE, frame_done<=1 alongside that valid_out.
- Channel boundaries: back-to-back, no idle cycle.
- Latency: output is registered one cycle after the accept/pad cycle.
- Throughput: 1 output/cycle while the source never stalls. Frame = CHANNEL_NUM*OUT_HEIGHT*OUT_WIDTH outputs, exactly CHANNEL_NUM*H*W inputs accepted.
- Back-to-back frames: after frame_done, IDLE costs exactly one cycle before the next frame starts.
- PAD=0: every position is interior; pure registered pass-through with backpressure.
- Output stream never carries X: pxl_out updates only when valid_out is set.

Decomposition:
- Shared package/header cnn_pad_defs: state encoding (IDLE=1'b0, RUN=1'b1), OUT_WIDTH/OUT_HEIGHT derivation, counter width via $clog2.
- Sub-module cnn_pad_position_counter:
  - Inputs: advance. Outputs: col/row/ch, is_interior, is_last.
  - Nested wrap counters plus the interior compare.
- Top level holds the FSM, the handshake, and the output registers.

Test Plan:
1. W=4,H=3,C=2,PAD=1, source always valid, pixels 1..24 -> 60 valid_out. Per channel: outputs 0..6 zero, output 7 = first pixel, outputs 11,12 zero; frame_done with output 60 only.
2. Same config, valid_in dropped 3 cycles at the 2nd interior pixel -> exactly 3 valid_out=0 bubbles, no pixel lost or duplicated. Pad runs do not stall when valid_in=0 during top-row pad.
3. PAD=0, W=4,H=2,C=1, pixels 0xA0..0xA7 -> 8 outputs identical and in order, 1-cycle latency after accept, frame_done with 0xA7.
4. reset driven low mid-channel 1 -> outputs clear immediately (asynchronous), no frame_done. New frame after release starts at (0,0,0) with 7 leading zeros.
5. Two frames back-to-back -> frame_done twice, one IDLE cycle between frames, 120 total outputs. Channel 0 of frame 2 starts with pad zeros.
6. Default config (304x304x64, PAD=1) smoke run -> 64*306*306 = 5,992,704 outputs, ready_out low on exactly 64*(306*306-304*304) = 78,080 RUN pad cycles.

Source files
------------

// File: rtl/cnn_pad_defs.sv
// Shared definitions for the zero-padding feeder: FSM encoding and
// padded-geometry / counter-width helpers.
package cnn_pad_defs;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pad_state_e;

    function automatic int out_dim(input int dim, input int pad);
        return dim + 2 * pad;
    endfunction

    // A counter that only ever holds 0 still needs one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_pad_position_counter.sv
// Column/row/channel position over the padded frame, with interior and
// last-position flags for the current position.
module cnn_pad_position_counter
    import cnn_pad_defs::*;
#(
    parameter int IMAGE_WIDTH  = 304,
    parameter int IMAGE_HEIGHT = 304,
    parameter int CHANNEL_NUM  = 64,
    parameter int PAD          = 1,
    localparam int OUT_WIDTH   = out_dim(IMAGE_WIDTH, PAD),
    localparam int OUT_HEIGHT  = out_dim(IMAGE_HEIGHT, PAD),
    localparam int CW          = cnt_width(OUT_WIDTH),
    localparam int RW          = cnt_width(OUT_HEIGHT),
    localparam int KW          = cnt_width(CHANNEL_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [KW-1:0] ch,
    output logic          is_interior,
    output logic          is_last
);

    localparam logic [CW-1:0] COL_MAX = CW'(OUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_HEIGHT - 1);
    localparam logic [KW-1:0] CH_MAX  = KW'(CHANNEL_NUM - 1);

    // One extra bit so the upper bound survives when PAD=0 and the image
    // dimension is a power of two.
    localparam logic [CW:0] COL_LO = (CW+1)'(PAD);
    localparam logic [CW:0] COL_HI = (CW+1)'(PAD + IMAGE_WIDTH);
    localparam logic [RW:0] ROW_LO = (RW+1)'(PAD);
    localparam logic [RW:0] ROW_HI = (RW+1)'(PAD + IMAGE_HEIGHT);

    logic col_last;
    logic row_last;
    logic ch_last;

    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);
    assign ch_last  = (ch == CH_MAX);
    assign is_last  = col_last && row_last && ch_last;

    assign is_interior = ({1'b0, col} >= COL_LO) && ({1'b0, col} < COL_HI) &&
                         ({1'b0, row} >= ROW_LO) && ({1'b0, row} < ROW_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    ch  <= ch_last ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_zero_padding_multi_channel.sv
// Frames each channel of a channel-major pixel stream with PAD zero pixels
// on every side, producing a registered valid-only output stream.
module cnn_zero_padding_multi_channel
    import cnn_pad_defs::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 304,
    parameter int IMAGE_HEIGHT = 304,
    parameter int CHANNEL_NUM  = 64,
    parameter int PAD          = 1,
    localparam int OUT_WIDTH   = out_dim(IMAGE_WIDTH, PAD),
    localparam int OUT_HEIGHT  = out_dim(IMAGE_HEIGHT, PAD),
    localparam int CW          = cnt_width(OUT_WIDTH),
    localparam int RW          = cnt_width(OUT_HEIGHT),
    localparam int KW          = cnt_width(CHANNEL_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  frame_done,
    output logic                  state_dbg,
    output logic [CW-1:0]         col_dbg,
    output logic [RW-1:0]         row_dbg,
    output logic [KW-1:0]         ch_dbg
);

    // Input handshake: a pixel moves on a rising edge where valid_in and
    // ready_out are both high; ready_out only rises on an interior position
    // in RUN. The output side has no ready: valid_out marks every word.
    pad_state_e state;
    logic       is_interior;
    logic       is_last;
    logic       advance;

    assign ready_out = (state == RUN) && is_interior;
    assign advance   = (state == RUN) && (!is_interior || valid_in);
    assign state_dbg = state;

    cnn_pad_position_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .CHANNEL_NUM (CHANNEL_NUM),
        .PAD         (PAD)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .col        (col_dbg),
        .row        (row_dbg),
        .ch         (ch_dbg),
        .is_interior(is_interior),
        .is_last    (is_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            valid_out  <= 1'b0;
            pxl_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) state <= RUN;
                end
                RUN: begin
                    // An interior position without valid_in holds and emits a bubble.
                    valid_out <= advance;
                    if (advance) begin
                        pxl_out <= is_interior ? pxl_in : '0;
                        if (is_last) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
